// File: rtl/led_sched_pkg.sv
// Shared mode encodings, pattern constants and pattern helpers for the LED scheduler.
// Pure definitions: no latency, no flow control.
package led_sched_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BINARY = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam int unsigned DEF_PRESCALE   = 2_500_000;
  localparam int unsigned DEF_DEB_CYCLES = 500_000;

  localparam logic [2:0] PAT_INIT_OFF    = 3'b000;
  localparam logic [2:0] PAT_INIT_BINARY = 3'b000;
  localparam logic [2:0] PAT_INIT_CHASE  = 3'b001;
  localparam logic [2:0] PAT_INIT_BLINK  = 3'b000;

  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    case (m)
      MODE_OFF:    r = MODE_BINARY;
      MODE_BINARY: r = MODE_CHASE;
      MODE_CHASE:  r = MODE_BLINK;
      default:     r = MODE_OFF;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] init_pattern(input mode_e m);
    logic [2:0] r;
    case (m)
      MODE_OFF:    r = PAT_INIT_OFF;
      MODE_BINARY: r = PAT_INIT_BINARY;
      MODE_CHASE:  r = PAT_INIT_CHASE;
      default:     r = PAT_INIT_BLINK;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] step_pattern(input mode_e m, input logic [2:0] p);
    logic [2:0] r;
    case (m)
      MODE_OFF:    r = 3'b000;
      MODE_BINARY: r = p + 3'd1;
      MODE_CHASE:  r = {p[1:0], p[2]};
      default:     r = ~p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counting debouncer and one-cycle press event for an active-low button.
// Latency: 2 sync + DEB_CYCLES cycles to a level change; no backpressure, event is a single pulse.
module btn_debounce
  import led_sched_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_evt
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          raw_pressed;
  logic [CW-1:0] cnt_q;

  assign raw_pressed = ~sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  // Any sample agreeing with the accepted level restarts the stability run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed   <= 1'b0;
      cnt_q     <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (raw_pressed == pressed) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        pressed   <= raw_pressed;
        cnt_q     <= '0;
        press_evt <= raw_pressed;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Button-selected LED pattern generator stepped by a prescaled tick; mode, led and tick are registered.
// Mode follows a qualified press by one cycle; no backpressure, enable=0 freezes the pattern.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned PRESCALE   = DEF_PRESCALE,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       enable,
  output logic [3:1] led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam logic [23:0] PS_LAST = 24'(PRESCALE - 1);

  logic        pressed;
  logic        press_evt;
  logic        mode_adv;
  mode_e       mode_q;
  mode_e       mode_d;
  logic [23:0] cnt_q;
  logic [23:0] cnt_d;
  logic [2:0]  led_q;
  logic [2:0]  led_d;
  logic        tick_q;
  logic        tick_d;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_n),
    .pressed   (pressed),
    .press_evt (press_evt)
  );

  assign mode_adv = press_evt & pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_OFF;
    else        mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_adv) mode_d = next_mode(mode_q);
  end

  // A mode change wins over a coinciding terminal count: the step is dropped.
  always_comb begin
    cnt_d  = cnt_q;
    led_d  = led_q;
    tick_d = 1'b0;
    if (mode_adv) begin
      cnt_d = '0;
      led_d = init_pattern(mode_d);
    end else if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == PS_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      led_d  = step_pattern(mode_q, led_q);
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      led_q  <= 3'b000;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed scoreboard bench for led_pattern_scheduler with PRESCALE=4, DEB_CYCLES=3.
// Expected tick and mode events are queued with their cycle numbers and checked as they appear.
module tb_led_pattern_scheduler;

  localparam int PS  = 4;
  localparam int DEB = 3;
  localparam int PRESS_LAT = 2 + DEB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       enable;
  logic [3:1] led;
  logic [1:0] mode;
  logic       tick;

  always #5 clk = ~clk;

  led_pattern_scheduler #(
    .PRESCALE   (PS),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n  (btn_n),
    .enable (enable),
    .led    (led),
    .mode   (mode),
    .tick   (tick)
  );

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } ev_t;

  ev_t        tick_q[$];
  ev_t        mode_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_mode = 2'd0;
  int         r0;
  int         r2;
  int         q0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2:0] init_led(input logic [1:0] m);
    return (m == 2'd2) ? 3'b001 : 3'b000;
  endfunction

  // Pattern after k ticks from the initial pattern of mode m.
  function automatic logic [2:0] pat_after(input logic [1:0] m, input int k);
    logic [2:0] r;
    case (m)
      2'd1:    r = 3'(k);
      2'd2:    r = (k % 3 == 0) ? 3'b001 : ((k % 3 == 1) ? 3'b010 : 3'b100);
      2'd3:    r = (k % 2 == 1) ? 3'b111 : 3'b000;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  task automatic push_tick(input int c, input logic [2:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    tick_q.push_back(e);
  endtask

  task automatic push_mode(input int c, input logic [1:0] m);
    ev_t e;
    e.cyc = c;
    e.val = {1'b0, m};
    mode_q.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    if (!mon_en || rst_n !== 1'b1) begin
      prev_mode = mode;
      return;
    end
    if (mode !== prev_mode) begin
      if (mode_q.size() == 0) begin
        chk("mode_evt_pending", 32'(mode_q.size()), 32'd1);
      end else begin
        e = mode_q.pop_front();
        chk("mode_val", 32'(mode), 32'(e.val));
        chk("mode_cyc", 32'(cyc), 32'(e.cyc));
        chk("mode_init_led", 32'(led), 32'(init_led(mode)));
      end
    end
    prev_mode = mode;
    if (tick === 1'b1) begin
      if (tick_q.size() == 0) begin
        chk("tick_evt_pending", 32'(tick_q.size()), 32'd1);
      end else begin
        e = tick_q.pop_front();
        chk("tick_cyc", 32'(cyc), 32'(e.cyc));
        chk("tick_led", 32'(led), 32'(e.val));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic press_hold(input logic [1:0] m, input int hold);
    push_mode(cyc + PRESS_LAT, m);
    btn_n = 1'b0;
    repeat (hold) step();
    btn_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    btn_n  = 1'b1;
    enable = 1'b1;
    repeat (2) step();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    step();
    rst_n  = 1'b1;
    r0     = cyc;
    mon_en = 1'b1;

    // Idle in OFF: ticks every PS cycles, led stays dark.
    for (int k = 1; k <= 11; k++) push_tick(r0 + PS * k, 3'b000);
    wait_until(r0 + 40);
    chk("idle_mode", 32'(mode), 32'd0);
    chk("idle_led", 32'(led), 32'd0);

    // Clean press; its mode change lands on a terminal count (r0+48), so that step is dropped.
    wait_until(r0 + 42);
    for (int k = 1; k <= 8; k++) push_tick(r0 + 48 + PS * k, pat_after(2'd1, k));
    press_hold(2'd1, 10);

    // Bouncy press settling low at r0+95.
    wait_until(r0 + 83);
    for (int k = 9; k <= 13; k++) push_tick(r0 + 84 + PS * (k - 9), pat_after(2'd1, k));
    for (int k = 1; k <= 3; k++) push_tick(r0 + 101 + PS * k, pat_after(2'd2, k));
    push_mode(r0 + 101, 2'd2);
    for (int i = 0; i < 6; i++) begin
      btn_n = (i % 2 == 1);
      repeat (2) step();
    end
    btn_n = 1'b0;
    repeat (10) step();
    btn_n = 1'b1;

    // Freeze CHASE with enable low for 10 cycles.
    wait_until(r0 + 115);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frozen_led", 32'(led), 32'b001);
      chk("frozen_tick", 32'(tick), 32'd0);
    end
    enable = 1'b1;
    for (int k = 4; k <= 7; k++) push_tick(r0 + 129 + PS * (k - 4), pat_after(2'd2, k));

    // Into BLINK.
    wait_until(r0 + 142);
    push_tick(r0 + 145, pat_after(2'd2, 8));
    for (int k = 1; k <= 5; k++) push_tick(r0 + 148 + PS * k, pat_after(2'd3, k));
    press_hold(2'd3, 10);

    // Reset two cycles into a fresh debounce while BLINK shows 111.
    wait_until(r0 + 169);
    chk("blink_led_pre_rst", 32'(led), 32'b111);
    btn_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    btn_n = 1'b1;
    #1;
    chk("midrst_led", 32'(led), 32'd0);
    chk("midrst_mode", 32'(mode), 32'd0);
    chk("midrst_tick", 32'(tick), 32'd0);
    chk("tickq_drained_at_rst", 32'(tick_q.size()), 32'd0);
    chk("modeq_drained_at_rst", 32'(mode_q.size()), 32'd0);
    step();
    rst_n = 1'b1;
    r2 = cyc;

    // Four clean presses: 1,2,3,0, four ticks each between them.
    q0 = r2 + 21;
    for (int k = 1; k <= 6; k++) push_tick(r2 + PS * k, 3'b000);
    for (int i = 0; i < 4; i++)
      for (int k = 1; k <= 4; k++)
        push_tick(q0 + 20 * i + PRESS_LAT + PS * k, pat_after(2'((i + 1) % 4), k));
    wait_until(q0);
    chk("no_phantom_press", 32'(mode), 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_until(q0 + 20 * i);
      press_hold(2'((i + 1) % 4), 10);
    end
    wait_until(q0 + 83);
    chk("final_mode", 32'(mode), 32'd0);
    chk("final_led", 32'(led), 32'd0);
    chk("tickq_drained", 32'(tick_q.size()), 32'd0);
    chk("modeq_drained", 32'(mode_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
